// File: rtl/mem_req_issuer.sv
// LSU-side initiator for the single-port data memory: queues LSQ requests and
// issues them one at a time, matching load returns by PC and emitting one completion each.
module mem_req_issuer #(
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned MEM_LATENCY = 10,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  input  logic [3:0]  req_optype,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_optype,
  output logic [31:0] mem_wdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic        mem_miss,
  input  logic [31:0] mem_rd_pc,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic        cmp_valid,
  output logic [31:0] cmp_pc,
  output logic [31:0] cmp_data,
  output logic        cmp_is_store,
  output logic        cmp_err
);

  localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);
  localparam int unsigned WMAX   = (MEM_LATENCY > TIMEOUT) ? MEM_LATENCY : TIMEOUT;
  localparam int unsigned WCNT_W = $clog2(WMAX + 1);

  localparam logic [3:0] OP_LB = 4'd7;
  localparam logic [3:0] OP_LW = 4'd8;
  localparam logic [3:0] OP_SB = 4'd9;
  localparam logic [3:0] OP_SW = 4'd10;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  optype;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SW);
  endfunction

  state_t             r_state;
  state_t             w_next;
  req_t               r_q [QDEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [31:0]        r_mem_pc;
  logic [31:0]        r_mem_addr;
  logic [3:0]         r_mem_optype;
  logic [31:0]        r_mem_wdata;
  logic               r_mem_read_en;
  logic               r_mem_write_en;
  logic               r_mem_miss;
  logic               r_cmp_valid;
  logic [31:0]        r_cmp_pc;
  logic [31:0]        r_cmp_data;
  logic               r_cmp_is_store;
  logic               r_cmp_err;

  req_t               w_req;
  req_t               w_head;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_cur_store;
  logic               w_hit;

  assign w_req       = '{pc: req_pc, optype: req_optype, addr: req_addr, wdata: req_wdata};
  assign w_head      = r_q[r_rptr];
  assign w_full      = (r_count == CNT_W'(QDEPTH));
  assign w_push      = req_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_cur_store = is_store(r_mem_optype);
  assign w_hit       = (r_state == S_WAIT) && !w_cur_store && mem_rd_valid &&
                       (mem_rd_pc == r_mem_pc);

  // Request FIFO storage; pointers wrap naturally since QDEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wptr] <= w_req;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_next = S_ISSUE;
      S_ISSUE: w_next = (is_load(r_mem_optype) || w_cur_store) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (w_cur_store) begin
          if (r_wcnt == WCNT_W'(MEM_LATENCY)) w_next = S_RESP;
        end else if (w_hit || (r_wcnt == WCNT_W'(TIMEOUT - 1))) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Issue-side registers: head latched on pop and held until the next pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt         <= '0;
      r_mem_pc       <= '0;
      r_mem_addr     <= '0;
      r_mem_optype   <= '0;
      r_mem_wdata    <= '0;
      r_mem_read_en  <= 1'b0;
      r_mem_write_en <= 1'b0;
      r_mem_miss     <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wcnt <= '0;
      else if (r_state == S_WAIT) r_wcnt <= r_wcnt + WCNT_W'(1);
      if (w_pop) begin
        r_mem_pc     <= w_head.pc;
        r_mem_addr   <= w_head.addr;
        r_mem_optype <= w_head.optype;
        r_mem_wdata  <= w_head.wdata;
      end
      r_mem_read_en  <= (w_next == S_ISSUE) && is_load(w_head.optype);
      r_mem_write_en <= (w_next == S_ISSUE) && is_store(w_head.optype);
      r_mem_miss     <= ((w_next == S_ISSUE) &&
                         (is_load(w_head.optype) || is_store(w_head.optype))) ||
                        (w_next == S_WAIT);
    end
  end

  // Completion registers; fields hold between pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmp_valid    <= 1'b0;
      r_cmp_pc       <= '0;
      r_cmp_data     <= '0;
      r_cmp_is_store <= 1'b0;
      r_cmp_err      <= 1'b0;
    end else begin
      r_cmp_valid <= (w_next == S_RESP);
      if (w_next == S_RESP) begin
        r_cmp_pc       <= r_mem_pc;
        r_cmp_is_store <= w_cur_store;
        r_cmp_err      <= (r_state == S_ISSUE) || (!w_cur_store && !w_hit);
        if (w_hit)
          r_cmp_data <= (r_mem_optype == OP_LB) ? {24'b0, mem_rd_data[7:0]} : mem_rd_data;
        else
          r_cmp_data <= '0;
      end
    end
  end

  assign req_ready    = rstn && !w_full;
  assign mem_pc       = r_mem_pc;
  assign mem_addr     = r_mem_addr;
  assign mem_optype   = r_mem_optype;
  assign mem_wdata    = r_mem_wdata;
  assign mem_read_en  = r_mem_read_en;
  assign mem_write_en = r_mem_write_en;
  assign mem_miss     = r_mem_miss;
  assign cmp_valid    = r_cmp_valid;
  assign cmp_pc       = r_cmp_pc;
  assign cmp_data     = r_cmp_data;
  assign cmp_is_store = r_cmp_is_store;
  assign cmp_err      = r_cmp_err;

endmodule

// File: tb/tb_mem_req_issuer.sv
// Directed bench for mem_req_issuer with a small fixed-latency memory model
// (load data returns 11 cycles after the read strobe).
module tb_mem_req_issuer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic [3:0]  req_optype;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_pc;
  logic [31:0] mem_addr;
  logic [3:0]  mem_optype;
  logic [31:0] mem_wdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        mem_miss;
  logic [31:0] mem_rd_pc;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        cmp_valid;
  logic [31:0] cmp_pc;
  logic [31:0] cmp_data;
  logic        cmp_is_store;
  logic        cmp_err;

  mem_req_issuer #(.QDEPTH(4), .MEM_LATENCY(10), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .req_optype(req_optype), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_pc(mem_pc), .mem_addr(mem_addr), .mem_optype(mem_optype),
    .mem_wdata(mem_wdata), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_miss(mem_miss), .mem_rd_pc(mem_rd_pc), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .cmp_valid(cmp_valid), .cmp_pc(cmp_pc),
    .cmp_data(cmp_data), .cmp_is_store(cmp_is_store), .cmp_err(cmp_err)
  );

  always #5 clk = ~clk;

  // Memory model: stores land on the strobe, loads answer 11 cycles after it
  logic [31:0] bmem [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;
  logic        rmode_bad_pc;
  int          rcd;
  logic [31:0] rpc;
  logic [31:0] raddr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rcd          <= 0;
      mem_rd_valid <= 1'b0;
      mem_rd_pc    <= '0;
      mem_rd_data  <= '0;
    end else begin
      mem_rd_valid <= 1'b0;
      if (rcd == 10) begin
        mem_rd_valid <= 1'b1;
        mem_rd_pc    <= rmode_bad_pc ? 32'h99 : rpc;
        mem_rd_data  <= bmem[raddr[3:0]];
        rcd          <= 0;
      end else if (rcd != 0) begin
        rcd <= rcd + 1;
      end
      if (mem_read_en) begin
        rcd   <= 1;
        rpc   <= mem_pc;
        raddr <= mem_addr;
      end
    end
  end

  always @(posedge clk) begin
    if (pl_en)        bmem[pl_addr] <= pl_data;
    if (mem_write_en) bmem[mem_addr[3:0]] <= mem_wdata;
  end

  // Negedge monitor: records completions and strobe/ordering events
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        st;
    logic        err;
    int          cyc;
  } cmp_rec_t;

  cmp_rec_t cq[$];
  int cyc = 0, rd_cyc = 0, dv_cyc = 0, n_strobe = 0, n_miss = 0, viol = 0;
  logic outst = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rstn) outst = 1'b0;
    if (mem_read_en || mem_write_en) begin
      if (mem_read_en) rd_cyc = cyc;
      n_strobe = n_strobe + 1;
      if (outst) viol = viol + 1;
      outst = 1'b1;
    end
    if (mem_miss) n_miss = n_miss + 1;
    if (mem_rd_valid) dv_cyc = cyc;
    if (cmp_valid) begin
      cq.push_back('{pc: cmp_pc, data: cmp_data, st: cmp_is_store, err: cmp_err, cyc: cyc});
      outst = 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [3:0] op,
                      input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_pc     = pc;
    req_optype = op;
    req_addr   = addr;
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic expect_cmp(input string tag, input logic [31:0] pc, input logic [31:0] data,
                            input logic st, input logic err, output int c);
    int k = 0;
    cmp_rec_t r;
    c = 0;
    while (cq.size() == 0 && k < 200) begin
      tick();
      k++;
    end
    if (cq.size() == 0) begin
      check({tag, "_present"}, 64'(cq.size()), 64'd1);
    end else begin
      r = cq.pop_front();
      c = r.cyc;
      check({tag, "_pc"},   64'(r.pc), 64'(pc));
      check({tag, "_data"}, 64'(r.data), 64'(data));
      check({tag, "_flags"}, 64'({r.st, r.err}), 64'({st, err}));
    end
  endtask

  task automatic wait_strobe(input string tag);
    int k = 0;
    while (!(mem_read_en || mem_write_en) && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_strobe_seen"}, 64'(mem_read_en || mem_write_en), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c, s0, m0;
    logic hold_ok;
    rstn = 1'b0; req_valid = 1'b0; req_pc = '0; req_optype = '0;
    req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    rmode_bad_pc = 1'b0;
    tick();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_outs", 64'({mem_read_en, mem_write_en, mem_miss, cmp_valid, cmp_err}), 64'd0);
    pl_en = 1'b1; pl_addr = 4'd5; pl_data = 32'hDEADBEEF; tick();
    pl_addr = 4'd6; pl_data = 32'h123456A7; tick();
    pl_en = 1'b0;
    rstn = 1'b1;
    tick();
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_cmp_pc", 64'(cmp_pc), 64'd0);

    // Single LW: completion one cycle after data, 12 cycles after the strobe
    push(32'h40, 4'd8, 32'd5, 32'd0);
    expect_cmp("lw", 32'h40, 32'hDEADBEEF, 1'b0, 1'b0, c);
    check("lw_lat", 64'(c - rd_cyc), 64'd12);
    check("lw_after_data", 64'(c - dv_cyc), 64'd1);

    push(32'h48, 4'd7, 32'd6, 32'd0);
    expect_cmp("lb", 32'h48, 32'h000000A7, 1'b0, 1'b0, c);

    // SW: strobe once, hold address/optype/data/miss for 11 WAIT cycles
    push(32'h44, 4'd10, 32'd3, 32'h55AA55AA);
    wait_strobe("sw");
    check("sw_is_write", 64'({mem_read_en, mem_write_en, mem_miss}), 64'b011);
    hold_ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (!(mem_miss && mem_addr == 32'd3 && mem_optype == 4'd10 &&
            mem_wdata == 32'h55AA55AA && !mem_write_en && !cmp_valid)) hold_ok = 1'b0;
    end
    check("sw_hold", 64'(hold_ok), 64'd1);
    tick();
    check("sw_resp", 64'({cmp_valid, cmp_is_store, mem_miss}), 64'b110);
    expect_cmp("sw", 32'h44, 32'd0, 1'b1, 1'b0, c);
    push(32'h4C, 4'd8, 32'd3, 32'd0);
    expect_cmp("lw_after_sw", 32'h4C, 32'h55AA55AA, 1'b0, 1'b0, c);

    // Queue full: five back-to-back, the first is popped at once
    s0 = n_strobe;
    push(32'h100, 4'd8,  32'd5, 32'd0);
    push(32'h104, 4'd10, 32'd7, 32'h00001111);
    push(32'h108, 4'd8,  32'd7, 32'd0);
    push(32'h10C, 4'd7,  32'd5, 32'd0);
    push(32'h110, 4'd8,  32'd6, 32'd0);
    check("full_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1; req_pc = 32'h114; req_optype = 4'd8; req_addr = 32'd5;
    tick(); tick();
    check("full_ready_hold", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    expect_cmp("q0", 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, c);
    expect_cmp("q1", 32'h104, 32'd0, 1'b1, 1'b0, c);
    expect_cmp("q2", 32'h108, 32'h00001111, 1'b0, 1'b0, c);
    expect_cmp("q3", 32'h10C, 32'h000000EF, 1'b0, 1'b0, c);
    expect_cmp("q4", 32'h110, 32'h123456A7, 1'b0, 1'b0, c);
    for (int i = 0; i < 30; i++) tick();
    check("full_no_extra", 64'(cq.size()), 64'd0);
    check("full_strobes", 64'(n_strobe - s0), 64'd5);

    // Mismatched return PC only: timeout error after 16 WAIT cycles
    rmode_bad_pc = 1'b1;
    push(32'h200, 4'd8, 32'd5, 32'd0);
    expect_cmp("lw_timeout", 32'h200, 32'd0, 1'b0, 1'b1, c);
    check("timeout_lat", 64'(c - rd_cyc), 64'd17);
    rmode_bad_pc = 1'b0;

    // Illegal optype: no strobe, no miss, error completion
    s0 = n_strobe;
    m0 = n_miss;
    push(32'h300, 4'd3, 32'd1, 32'd0);
    expect_cmp("illegal", 32'h300, 32'd0, 1'b0, 1'b1, c);
    check("illegal_no_strobe", 64'(n_strobe - s0), 64'd0);
    check("illegal_no_miss", 64'(n_miss - m0), 64'd0);

    // Reset pulsed mid-WAIT: request abandoned silently
    push(32'h400, 4'd8, 32'd5, 32'd0);
    wait_strobe("rst_mid");
    tick(); tick(); tick();
    check("rst_mid_pre_miss", 64'(mem_miss), 64'd1);
    rstn = 1'b0;
    #1;
    check("rst_mid_async", 64'({mem_miss, mem_read_en, cmp_valid}), 64'd0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check("rst_mid_no_cmp", 64'(cq.size()), 64'd0);
    check("rst_mid_ready", 64'({req_ready, mem_miss}), 64'b10);

    push(32'h500, 4'd8, 32'd6, 32'd0);
    expect_cmp("post_rst_lw", 32'h500, 32'h123456A7, 1'b0, 1'b0, c);
    check("one_outstanding", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_issuer.md
Name: mem_req_issuer

Overview:
- Initiator side of the single-port data-memory interface: the LSU-side controller that queues load/store requests from the LSQ and issues them one at a time to the 1R/W data memory.
- Tracks the fixed-latency memory pipeline and matches returned load data by instruction PC.
- Produces one completion pulse per request toward the CDB/ROB.
- Enforces the memory's rule of one outstanding instruction at a time; stalls upstream via req_ready.

Parameters:
QDEPTH, 4, request queue entries (power of 2)
MEM_LATENCY, 10, cycles from store issue until the write is committed in memory
TIMEOUT, 16, max WAIT cycles for load data before an error completion

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
req_valid  in  1  LSQ request valid
req_ready  out  1  queue not full
req_pc  in  32  instruction PC (request tag)
req_optype  in  4  7=LB, 8=LW, 9=SB, 10=SW
req_addr  in  32  word address
req_wdata  in  32  store data
mem_pc  out  32  PC of the issued request
mem_addr  out  32  address to memory
mem_optype  out  4  optype to memory
mem_wdata  out  32  store data to memory
mem_read_en  out  1  load strobe, 1-cycle pulse
mem_write_en  out  1  store strobe, 1-cycle pulse
mem_miss  out  1  cacheMiss qualifier, high from ISSUE through end of WAIT
mem_rd_pc  in  32  PC returned with load data
mem_rd_data  in  32  returned load data
mem_rd_valid  in  1  load data valid
cmp_valid  out  1  completion pulse
cmp_pc  out  32  completed PC
cmp_data  out  32  load result (0 for stores/errors)
cmp_is_store  out  1  completed op was SB/SW
cmp_err  out  1  timeout or illegal optype

Behaviour:
- Reset (async): queue emptied, FSM=IDLE, all outputs 0 (req_ready=1 once rstn deasserts). Reset mid-operation abandons the in-flight request with no completion; strobes drop immediately.
- Queue:
  - FIFO of {pc, optype, addr, wdata}.
  - req_ready = (count != QDEPTH), from registered count. When full, no enqueue even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged. Pointers wrap modulo QDEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when queue non-empty. Head is popped and latched into mem_pc/mem_addr/mem_optype/mem_wdata.
- ISSUE (1 cycle):
  - Drive mem_read_en=1 for LB/LW, or mem_write_en=1 for SB/SW; assert mem_miss=1.
  - Illegal optype: no strobe, no mem_miss, go straight to RESP with cmp_err=1.
  - Otherwise go to WAIT with wait counter cleared to 0.
- WAIT:
  - mem_pc/addr/optype/wdata and mem_miss held stable for the whole state (memory samples addr/optype at the delayed write-commit time).
  - Counter increments every cycle.
  - Load: mem_rd_valid=1 && mem_rd_pc==latched pc -> capture data, go to RESP. A valid with mismatched PC is ignored. Counter reaching TIMEOUT-1 without a match -> RESP with cmp_err=1, cmp_data=0.
  - Store: counter reaching MEM_LATENCY -> RESP. mem_rd_valid is ignored during stores.
- RESP (1 cycle):
  - cmp_valid=1 with cmp_pc, cmp_is_store, cmp_err.
  - cmp_data = {24'b0, data[7:0]} for LB, full word for LW, 0 otherwise.
  - mem_miss drops to 0.
  - Next state: IDLE. The next request issues no earlier than the cycle after IDLE, so back-to-back requests have a 1-cycle gap.
- cmp_* fields hold their last values when cmp_valid=0. There is no completion backpressure.
- At most one memory request outstanding at any time; no issue strobe ever fires while in WAIT or RESP.

Test Plan:
- Single LW: pc=0x40, addr=5, memory returns data 0xDEADBEEF with mem_rd_pc=0x40 11 cycles after mem_read_en -> one cmp_valid, cmp_pc=0x40, cmp_data=0xDEADBEEF, cmp_err=0, one cycle after the data.
- LB: returned data 0x123456A7 -> cmp_data=0x000000A7.
- SW: pc=0x44, addr=3, wdata=0x55AA55AA -> mem_write_en pulses once; addr/optype/wdata/mem_miss held 11 WAIT cycles; cmp_valid with cmp_is_store=1; a following LW to addr 3 reads 0x55AA55AA.
- Queue full: 5 back-to-back requests -> req_ready=0 after the 4th is queued; completions appear in PC order; no second strobe before the previous cmp_valid.
- Load with mismatched mem_rd_pc=0x99 and no correct return -> ignored; cmp_err=1 and cmp_data=0 after TIMEOUT cycles.
- Illegal optype 3 -> no mem strobe, cmp_err=1. rstn pulsed mid-WAIT -> no cmp_valid, req_ready=1, mem_miss=0.
